// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word at a time over a req/ack
// handshake, presents it to decode and computes the next PC when the core retires it.
module instr_fetch_unit #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            retire,
  input  logic            pc_src,
  input  logic [XLEN-1:0] imm_ext,
  output logic            fetch_fault
);

  localparam logic [XLEN-1:0] Nop = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {
    StFetch = 2'b00,
    StValid = 2'b01,
    StFault = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] target;

  // Both adds wrap modulo 2^XLEN; the carry out is intentionally dropped.
  assign target = pc_src ? (pc_q + imm_ext) : (pc_q + XLEN'(4));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      StFetch: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StValid;
        end
      end
      StValid: begin
        if (retire) begin
          if (target[1:0] != 2'b00) begin
            state_d = StFault;
          end else begin
            pc_d    = target;
            state_d = StFetch;
          end
        end
      end
      StFault: state_d = StFault;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      instr_q <= Nop;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Gating with rst_n keeps the request low for the whole time reset is held.
  assign imem_req    = rst_n && (state_q == StFetch);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + XLEN'(4);
  assign instr       = instr_q;
  assign instr_valid = (state_q == StValid);
  assign fetch_fault = (state_q == StFault);

endmodule
